// File: rtl/ks_pkg.sv
// Shared types and widths for the Kogge-Stone limb sequencer and its adder core.
package ks_pkg;

  localparam int LIMB_W = 32;
  localparam int SUM_W  = 33;

  typedef enum logic {
    ST_FIRST,
    ST_MID
  } state_e;

endpackage

// File: rtl/ks_limb_sequencer.sv
// Streams LSB-first operand limbs through an external 32-bit adder, chaining carry
// between limbs and registering each sum limb into a 1-deep output pipe.
module ks_limb_sequencer
  import ks_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] in_a,
  input  logic [LIMB_W-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_last,
  output logic [LIMB_W-1:0] add_x,
  output logic [LIMB_W-1:0] add_y,
  output logic              add_cin,
  input  logic [SUM_W-1:0]  add_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic              len_err
);

  localparam int               CNT_W   = $clog2(LIMBS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMBS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              out_valid_q, out_valid_d;
  logic [LIMB_W-1:0] out_sum_q, out_sum_d;
  logic              out_last_q, out_last_d;
  logic              out_cout_q, out_cout_d;
  logic              len_err_q, len_err_d;

  logic accept;
  logic at_max;
  logic close;

  assign accept = in_valid & in_ready;
  assign at_max = (cnt_q == CNT_MAX);
  assign close  = in_last | at_max;

  // State register. The output pipe is reset explicitly so a partial
  // operation cannot surface a stale limb after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    if (!rst_n) begin
      state_q     <= ST_FIRST;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      len_err_q   <= len_err_d;
    end
  end

  // Next-state logic: an accepted limb either closes the operation or stays inside it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = close ? ST_FIRST : ST_MID;
    end
  end

  // Datapath next values for counter, carry chain and output pipe.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path leaves it unassigned
    // and no latch is inferred.
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    len_err_d   = len_err_q;

    if (accept) begin
      out_sum_d   = add_s[LIMB_W-1:0];
      out_valid_d = 1'b1;
      carry_d     = add_s[LIMB_W];
      if (close) begin
        cnt_d      = '0;
        out_last_d = 1'b1;
        out_cout_d = add_s[LIMB_W];
      end else begin
        cnt_d      = cnt_q + CNT_W'(1);
        out_last_d = 1'b0;
        out_cout_d = 1'b0;
      end
      // Hitting the limb limit without in_last forces the operation closed.
      if (at_max && !in_last) begin
        len_err_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Outputs: adder feed and handshake. The first limb takes the external carry-in,
  // so carry_q never leaks from one operation into the next.
  always_comb begin
    in_ready = rst_n & (~out_valid_q | out_ready);
    add_x    = in_a;
    add_y    = in_b;
    add_cin  = (state_q == ST_FIRST) ? in_cin : carry_q;
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_ks_limb_sequencer.sv
// Directed and randomised checks of ks_limb_sequencer with a behavioural adder core
// and a scoreboard of expected sum limbs.
module tb_ks_limb_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_last;
  logic [31:0] add_x;
  logic [31:0] add_y;
  logic        add_cin;
  logic [32:0] add_s;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_last;
  logic        out_cout;
  logic        len_err;

  typedef struct packed {
    logic [31:0] sum;
    logic        last;
    logic        cout;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    rand_mode = 1'b0;

  localparam int N_OPS = 5000;

  ks_limb_sequencer #(.LIMBS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_last   (in_last),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .len_err   (len_err)
  );

  // Behavioural stand-in for the 32-bit Kogge-Stone adder core.
  assign add_s = {1'b0, add_x} + {1'b0, add_y} + {32'b0, add_cin};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one limb, wait (bounded) for acceptance, and record the expected beat.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic last, input logic [31:0] es, input logic el,
                      input logic ec, input logic ecin, input bit chk_cin);
    int    n;
    beat_t nb;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      if (chk_cin) check("add_cin", add_cin, ecin);
      nb.sum  = es;
      nb.last = el;
      nb.cout = ec;
      exp_q.push_back(nb);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Output monitor: every completed output handshake pops one expected beat.
  always @(negedge clk) begin : mon
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_sum", out_sum, e.sum);
        check("out_last", out_last, e.last);
        check("out_cout", out_cout, e.cout);
      end
    end
  end

  initial begin : stim
    logic [127:0] op_a;
    logic [127:0] op_b;
    logic         op_cin;
    logic [128:0] ref_sum;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_cout", out_cout, 1'b0);
    check("rst_len_err", len_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1'b1);

    // Single-limb operation with carry out.
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Four-limb carry ripple: every limb sums to 0 and propagates carry 1.
    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Back-to-back: previous op ended with carry 1, new op must take in_cin=0.
    send(32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure: hold out_ready low for 3 cycles with a beat pending.
    tick();
    tick();
    out_ready = 1'b0;
    send(32'h5, 32'h6, 1'b0, 1'b0, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1);
    in_a     = 32'h7;
    in_b     = 32'h8;
    in_cin   = 1'b1;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_out_sum", out_sum, 32'hB);
      tick();
    end
    out_ready = 1'b1;
    send(32'h7, 32'h8, 1'b1, 1'b1, 32'hF, 1'b1, 1'b0, 1'b0, 1'b1);
    check("len_err_clear", len_err, 1'b0);

    // Five limbs without in_last: limb 4 is forced closed, limb 5 starts a new op.
    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("len_err_before_limit", len_err, 1'b0);
    send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("len_err_set", len_err, 1'b1);
    send(32'h1, 32'h2, 1'b0, 1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 1'b1);
    check("len_err_sticky", len_err, 1'b1);

    // Reset after 2 of 4 limbs: the partial op is discarded.
    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_len_err", len_err, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    check("postrst_out_valid", out_valid, 1'b0);
    send(32'h1, 32'h1, 1'b1, 1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 1'b1);

    // Random 128-bit operations against a wide reference sum, with stalls.
    rand_mode = 1'b1;
    for (int op = 0; op < N_OPS; op++) begin
      op_a    = {$urandom, $urandom, $urandom, $urandom};
      op_b    = {$urandom, $urandom, $urandom, $urandom};
      op_cin  = 1'($urandom_range(0, 1));
      if (op % 8 == 0) op_b = ~op_a;
      ref_sum = {1'b0, op_a} + {1'b0, op_b} + {128'b0, op_cin};
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send(op_a[32*l +: 32], op_b[32*l +: 32], (l == 0) ? op_cin : 1'($urandom_range(0, 1)),
             (l == 3), ref_sum[32*l +: 32], (l == 3), (l == 3) ? ref_sum[128] : 1'b0,
             1'b0, 1'b0);
      end
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
